face_tile_scheduler: RTL and testbench
======================================

Name: face_tile_scheduler

Overview:
- Frame-level controller for the face-detection manycore array.
- Accepts a frame command, hands tile IDs 0..N-1 to free detection cores, and broadcasts the tile size.
- Collects per-core completion requests through a round-robin acknowledge arbiter and reports frame completion.
- Sits between the host/frame loader and the NUM_CORES detection cores.

Parameters:
NUM_CORES, 8, number of detection cores scheduled
TILE_ID_W, 8, width of tile index and tile count
SIZE_W, 32, width of the image size field forwarded to cores

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
frame_start  in  1  one-cycle pulse that starts a frame
frame_tiles  in  TILE_ID_W  tiles in frame; sampled with frame_start
frame_size  in  SIZE_W  image size; sampled with frame_start
core_start  out  NUM_CORES  one-hot, one-cycle start pulse to the selected core
core_tile_id  out  TILE_ID_W  tile index; valid in the core_start cycle
core_size  out  SIZE_W  latched frame_size; held for the whole frame
core_done_req  in  NUM_CORES  per-core completion request; level, held until acked
core_done_ack  out  NUM_CORES  one-hot, one-cycle acknowledge
frame_busy  out  1  high from the cycle after an accepted frame_start until frame_done
frame_done  out  1  one-cycle pulse when all tiles are acknowledged
tiles_done  out  TILE_ID_W  count of acknowledged tiles in the current frame
err_start_busy  out  1  one-cycle pulse: frame_start arrived while busy
err_spurious_done  out  1  one-cycle pulse: done_req from a core not marked busy

Behaviour:
- Reset: every output is 0 and core_size is 0. Internal state is cleared: busy vector 0, next_tile 0, rr pointer 0, FSM in IDLE. Reset mid-frame abandons the frame with no frame_done. Cores are reset by their own reset.
- All outputs are registered.
- FSM states: IDLE, RUN, FINISH.
- IDLE:
  - frame_start latches frame_tiles/frame_size, clears tiles_done and next_tile, and moves to RUN.
  - If frame_tiles == 0, go to FINISH instead.
- RUN, dispatch:
  - Each cycle, if next_tile < frame_tiles and any core is free, the lowest-index free core gets core_start[k]=1 with core_tile_id=next_tile.
  - That core is marked busy and next_tile increments.
  - At most one dispatch per cycle.
  - The first core_start appears 1 cycle after frame_start.
- RUN, acknowledge:
  - Each cycle, among core_done_req bits that are also busy, grant one by round robin starting at rr pointer.
  - Assert core_done_ack for one cycle, clear that core's busy bit, increment tiles_done, and set rr pointer to grant+1 mod NUM_CORES.
- Dispatch and acknowledge may occur in the same cycle. A core freed by an ack is eligible for dispatch in the following cycle, never the same cycle.
- A core holding done_req after an ack has its request ignored until it is busy again. Because ack clears busy, no double count is possible.
- done_req from a non-busy core gives an err_spurious_done pulse and is otherwise ignored. This applies in all states.
- RUN to FINISH when tiles_done (post-increment) == frame_tiles.
- FINISH: frame_done=1 for one cycle, frame_busy drops in the same cycle, then IDLE. A new frame_start is accepted in the cycle after FINISH.
- frame_start in RUN or FINISH: ignored, err_start_busy pulse, latched values unchanged.
- Widths: tiles_done and next_tile are TILE_ID_W and never wrap, because they saturate at frame_tiles ≤ 2^TILE_ID_W-1.

Decomposition:
- Shared package face_mc_pkg:
  - FSM state enum (IDLE/RUN/FINISH)
  - NUM_CORES, TILE_ID_W, SIZE_W defaults
  - tile_id_t and core_vec_t typedefs
- One sub-module: rr_arbiter_onehot.
  - Parameterised NUM_CORES.
  - Inputs: req vector, pointer. Outputs: one-hot grant, grant index.
  - Purely combinational; reused later for the result-merge memory port.

Test Plan:
- Basic frame: NUM_CORES=8, frame_tiles=3, frame_size=64, cores reply 10 cycles after start.
  - core_start 0x01/0x02/0x04 on cycles 1/2/3 with tile_id 0/1/2.
  - Three acks, then frame_done exactly once with tiles_done=3. core_size=64 throughout.
- Oversubscription: frame_tiles=20, all 8 cores busy.
  - No core_start until an ack. The freed core restarts the cycle after its ack.
  - Tile IDs 0..19 are each issued exactly once.
- Round-robin fairness: cores 0,3,5 raise done_req in the same cycle with pointer=4.
  - Acks in order 5, 0, 3 on three consecutive cycles.
- Zero-tile frame: frame_start with frame_tiles=0.
  - frame_done pulses 1 cycle later, no core_start.
- Errors: frame_start during RUN gives err_start_busy and the frame is unaffected. done_req from an idle core 2 gives err_spurious_done and no ack.
- Reset mid-frame: assert reset after 5 dispatches.
  - All outputs are 0 immediately. A subsequent frame with frame_tiles=2 starts tile_id 0 on core 0.

Source files
------------

// File: rtl/face_tile_scheduler_pkg.sv
// Shared types and defaults for the face-detection manycore frame scheduler.
package face_mc_pkg;

    localparam int NUM_CORES_DEF = 8;
    localparam int TILE_ID_W_DEF = 8;
    localparam int SIZE_W_DEF    = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } sched_state_e;

    typedef logic [TILE_ID_W_DEF-1:0] tile_id_t;
    typedef logic [NUM_CORES_DEF-1:0] core_vec_t;

endpackage

// File: rtl/face_tile_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr_i wins.
module rr_arbiter_onehot #(
    parameter int NUM_CORES = 8,
    parameter int IDX_W     = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic [NUM_CORES-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_CORES-1:0] grant_o,
    output logic [IDX_W-1:0]     grant_idx_o
);

    logic [IDX_W-1:0] idx_s;
    logic             hit_s;
    logic             taken_s;

    // scan the request vector starting at the pointer, wrapping once
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        idx_s       = '0;
        hit_s       = 1'b0;
        taken_s     = 1'b0;
        for (int i = 0; i < NUM_CORES; i++) begin
            idx_s          = IDX_W'((int'(ptr_i) + i) % NUM_CORES);
            hit_s          = req_i[idx_s] & ~taken_s;
            grant_o[idx_s] = hit_s;
            grant_idx_o    = hit_s ? idx_s : grant_idx_o;
            taken_s        = taken_s | hit_s;
        end
    end

endmodule

// File: rtl/face_tile_scheduler.sv
// Frame controller: hands tile IDs to free detection cores and collects their
// completion requests through a round-robin acknowledge arbiter.
module face_tile_scheduler
    import face_mc_pkg::*;
#(
    parameter int NUM_CORES = NUM_CORES_DEF,
    parameter int TILE_ID_W = TILE_ID_W_DEF,
    parameter int SIZE_W    = SIZE_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_start,
    input  logic [TILE_ID_W-1:0] frame_tiles,
    input  logic [SIZE_W-1:0]    frame_size,
    output logic [NUM_CORES-1:0] core_start,
    output logic [TILE_ID_W-1:0] core_tile_id,
    output logic [SIZE_W-1:0]    core_size,
    input  logic [NUM_CORES-1:0] core_done_req,
    output logic [NUM_CORES-1:0] core_done_ack,
    output logic                 frame_busy,
    output logic                 frame_done,
    output logic [TILE_ID_W-1:0] tiles_done,
    output logic                 err_start_busy,
    output logic                 err_spurious_done
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [TILE_ID_W-1:0] TILE_ONE = TILE_ID_W'(1'b1);
    localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1'b1);
    localparam logic [NUM_CORES-1:0] CORE_ONE = NUM_CORES'(1'b1);

    sched_state_e         state_q, state_d;
    logic [NUM_CORES-1:0] busy_q, busy_d;
    logic [NUM_CORES-1:0] hold_q, hold_d;
    logic [TILE_ID_W-1:0] next_tile_q, next_tile_d;
    logic [TILE_ID_W-1:0] tiles_done_q, tiles_done_d;
    logic [TILE_ID_W-1:0] frame_tiles_q, frame_tiles_d;
    logic [SIZE_W-1:0]    core_size_q, core_size_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_CORES-1:0] core_start_q;
    logic [TILE_ID_W-1:0] core_tile_id_q, core_tile_id_d;
    logic [NUM_CORES-1:0] core_done_ack_q;
    logic                 frame_busy_q, frame_busy_d;
    logic                 frame_done_q, frame_done_d;
    logic                 err_start_busy_q, err_start_busy_d;
    logic                 err_spurious_q, err_spurious_d;

    logic [NUM_CORES-1:0] free_onehot_s;
    logic                 free_any_s;
    logic [NUM_CORES-1:0] grant_s;
    logic [IDX_W-1:0]     grant_idx_s;
    logic                 grant_any_s;
    logic [NUM_CORES-1:0] start_vec_s;
    logic [NUM_CORES-1:0] ack_vec_s;

    // Lowest clear bit of busy_q, isolated as ~x & (x+1).
    assign free_onehot_s = ~busy_q & (busy_q + CORE_ONE);
    assign free_any_s    = |free_onehot_s;
    assign grant_any_s   = |grant_s;

    rr_arbiter_onehot #(
        .NUM_CORES (NUM_CORES),
        .IDX_W     (IDX_W)
    ) u_ack_arb (
        .req_i       (core_done_req & busy_q),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant_s),
        .grant_idx_o (grant_idx_s)
    );

    // next-state, dispatch and acknowledge decisions
    always_comb begin
        state_d          = state_q;
        frame_tiles_d    = frame_tiles_q;
        core_size_d      = core_size_q;
        next_tile_d      = next_tile_q;
        tiles_done_d     = tiles_done_q;
        rr_ptr_d         = rr_ptr_q;
        start_vec_s      = '0;
        ack_vec_s        = '0;
        core_tile_id_d   = '0;
        frame_busy_d     = frame_busy_q;
        frame_done_d     = 1'b0;
        err_start_busy_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    frame_tiles_d = frame_tiles;
                    core_size_d   = frame_size;
                    tiles_done_d  = '0;
                    next_tile_d   = '0;
                    if (frame_tiles == '0) begin
                        state_d      = ST_FINISH;
                        frame_done_d = 1'b1;
                        frame_busy_d = 1'b0;
                    end else begin
                        // tile 0 goes out on the accepting edge itself
                        state_d      = ST_RUN;
                        frame_busy_d = 1'b1;
                        start_vec_s  = free_onehot_s;
                        next_tile_d  = free_any_s ? TILE_ONE : '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                err_start_busy_d = frame_start;
                if ((next_tile_q < frame_tiles_q) && free_any_s) begin
                    start_vec_s    = free_onehot_s;
                    core_tile_id_d = next_tile_q;
                    next_tile_d    = next_tile_q + TILE_ONE;
                end else begin
                    start_vec_s = '0;
                end
                if (grant_any_s) begin
                    ack_vec_s    = grant_s;
                    tiles_done_d = tiles_done_q + TILE_ONE;
                    rr_ptr_d     = (grant_idx_s == IDX_W'(NUM_CORES - 1)) ? '0 : grant_idx_s + IDX_ONE;
                    if ((tiles_done_q + TILE_ONE) == frame_tiles_q) begin
                        state_d      = ST_FINISH;
                        frame_done_d = 1'b1;
                        frame_busy_d = 1'b0;
                    end else begin
                        state_d = ST_RUN;
                    end
                end else begin
                    ack_vec_s = '0;
                end
            end
            ST_FINISH: begin
                err_start_busy_d = frame_start;
                state_d          = ST_IDLE;
            end
            default: begin
                state_d      = ST_IDLE;
                frame_busy_d = 1'b0;
            end
        endcase
        busy_d = (busy_q | start_vec_s) & ~ack_vec_s;
        // A request still held just after its ack is ignored quietly until the core is re-dispatched.
        hold_d         = ((hold_q & core_done_req) | ack_vec_s) & ~start_vec_s;
        err_spurious_d = |(core_done_req & ~busy_q & ~hold_q);
    end

    // state and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            busy_q           <= '0;
            hold_q           <= '0;
            next_tile_q      <= '0;
            tiles_done_q     <= '0;
            frame_tiles_q    <= '0;
            core_size_q      <= '0;
            rr_ptr_q         <= '0;
            core_start_q     <= '0;
            core_tile_id_q   <= '0;
            core_done_ack_q  <= '0;
            frame_busy_q     <= 1'b0;
            frame_done_q     <= 1'b0;
            err_start_busy_q <= 1'b0;
            err_spurious_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            busy_q           <= busy_d;
            hold_q           <= hold_d;
            next_tile_q      <= next_tile_d;
            tiles_done_q     <= tiles_done_d;
            frame_tiles_q    <= frame_tiles_d;
            core_size_q      <= core_size_d;
            rr_ptr_q         <= rr_ptr_d;
            core_start_q     <= start_vec_s;
            core_tile_id_q   <= core_tile_id_d;
            core_done_ack_q  <= ack_vec_s;
            frame_busy_q     <= frame_busy_d;
            frame_done_q     <= frame_done_d;
            err_start_busy_q <= err_start_busy_d;
            err_spurious_q   <= err_spurious_d;
        end
    end

    assign core_start        = core_start_q;
    assign core_tile_id      = core_tile_id_q;
    assign core_size         = core_size_q;
    assign core_done_ack     = core_done_ack_q;
    assign frame_busy        = frame_busy_q;
    assign frame_done        = frame_done_q;
    assign tiles_done        = tiles_done_q;
    assign err_start_busy    = err_start_busy_q;
    assign err_spurious_done = err_spurious_q;

endmodule

// File: tb/tb_face_tile_scheduler.sv
// Scoreboard bench for face_tile_scheduler: random frames and core latencies
// against a cycle-level reference model of the scheduling rules.
module tb_face_tile_scheduler;
    import face_mc_pkg::*;

    localparam int NC = 8;
    localparam int TW = 8;
    localparam int SW = 32;
    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_FIN  = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          frame_start;
    logic [TW-1:0] frame_tiles;
    logic [SW-1:0] frame_size;
    core_vec_t     core_start, core_done_req, core_done_ack;
    logic [TW-1:0] core_tile_id, tiles_done;
    logic [SW-1:0] core_size;
    logic          frame_busy, frame_done, err_start_busy, err_spurious_done;

    face_tile_scheduler #(.NUM_CORES(NC), .TILE_ID_W(TW), .SIZE_W(SW)) dut (
        .clk               (clk),
        .reset             (reset),
        .frame_start       (frame_start),
        .frame_tiles       (frame_tiles),
        .frame_size        (frame_size),
        .core_start        (core_start),
        .core_tile_id      (core_tile_id),
        .core_size         (core_size),
        .core_done_req     (core_done_req),
        .core_done_ack     (core_done_ack),
        .frame_busy        (frame_busy),
        .frame_done        (frame_done),
        .tiles_done        (tiles_done),
        .err_start_busy    (err_start_busy),
        .err_spurious_done (err_spurious_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // scoreboard queues: pushed by the stimulus, popped by the monitor
    int exp_tile_q[$];
    int exp_done_q[$];

    // reference model, owned by the monitor
    int        m_phase = P_IDLE;
    core_vec_t m_busy  = '0;
    int        m_ptr   = 0;
    int        m_next  = 0;
    int        m_acked = 0;
    int        m_tiles = 0;
    logic [SW-1:0] m_size = '0;
    int        done_cnt  = 0;
    int        start_cnt = 0;

    // core behaviour knobs, owned by the stimulus
    int lat_min  = 10;
    int lat_max  = 10;
    int spur_req = 0;

    function automatic core_vec_t lowest_free(input core_vec_t b);
        for (int i = 0; i < NC; i++)
            if (!b[i]) return core_vec_t'(1) << i;
        return '0;
    endfunction

    // core responders: start -> wait latency -> raise done_req -> drop on ack
    initial begin
        int        cnt[NC];
        core_vec_t req_v;
        int        spur_seen;
        req_v = '0;
        spur_seen = 0;
        core_done_req = '0;
        for (int k = 0; k < NC; k++) cnt[k] = 0;
        forever begin
            @(posedge clk);
            #2;
            if (reset) begin
                req_v = '0;
                for (int k = 0; k < NC; k++) cnt[k] = 0;
            end else begin
                for (int k = 0; k < NC; k++) begin
                    if (core_done_ack[k]) req_v[k] = 1'b0;
                    if (core_start[k]) cnt[k] = $urandom_range(lat_max, lat_min);
                    else if (cnt[k] > 0) begin
                        cnt[k]--;
                        if (cnt[k] == 0) req_v[k] = 1'b1;
                    end
                end
            end
            if (spur_seen != spur_req) begin
                core_done_req = req_v | 8'h04;
                spur_seen = spur_req;
            end else begin
                core_done_req = req_v;
            end
        end
    end

    // monitor: advance the model by one cycle and compare every output
    initial begin
        logic          sv_fs;
        logic [TW-1:0] sv_ft;
        logic [SW-1:0] sv_fsz;
        core_vec_t     sv_req, e_start, e_ack, cand;
        logic          e_done, e_sb, e_sp;
        int            nph, t;
        sv_fs = 1'b0; sv_ft = '0; sv_fsz = '0; sv_req = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                m_phase = P_IDLE; m_busy = '0; m_ptr = 0; m_next = 0;
                m_acked = 0; m_tiles = 0; m_size = '0;
                chk("reset_ctrl", {core_start, core_tile_id, core_done_ack, frame_busy, frame_done,
                                   tiles_done, err_start_busy, err_spurious_done}, 64'd0);
                chk("reset_size", core_size, 64'd0);
            end else begin
                e_start = '0; e_ack = '0; e_done = 1'b0; nph = m_phase;
                e_sb = sv_fs && (m_phase != P_IDLE);
                e_sp = |(sv_req & ~m_busy);
                if (m_phase == P_IDLE) begin
                    if (sv_fs) begin
                        m_tiles = int'(sv_ft); m_size = sv_fsz; m_acked = 0; m_next = 0;
                        if (m_tiles == 0) begin
                            e_done = 1'b1; nph = P_FIN;
                        end else begin
                            e_start = lowest_free(m_busy); m_next = 1; nph = P_RUN;
                        end
                    end
                end else if (m_phase == P_RUN) begin
                    if (m_next < m_tiles && m_busy != '1) begin
                        e_start = lowest_free(m_busy);
                        m_next++;
                    end
                    cand = sv_req & m_busy;
                    if (cand != '0) begin
                        for (int i = 0; i < NC; i++) begin
                            t = (m_ptr + i) % NC;
                            if (cand[t] && e_ack == '0) e_ack[t] = 1'b1;
                        end
                        for (int i = 0; i < NC; i++)
                            if (e_ack[i]) m_ptr = (i + 1) % NC;
                        m_acked++;
                        if (m_acked == m_tiles) begin
                            e_done = 1'b1; nph = P_FIN;
                        end
                    end
                end else begin
                    nph = P_IDLE;
                end
                m_busy  = (m_busy | e_start) & ~e_ack;
                m_phase = nph;
                chk("core_start", core_start, e_start);
                chk("core_done_ack", core_done_ack, e_ack);
                chk("frame_done", frame_done, e_done);
                chk("frame_busy", frame_busy, m_phase == P_RUN);
                chk("tiles_done", tiles_done, m_acked);
                chk("core_size", core_size, m_size);
                chk("err_start_busy", err_start_busy, e_sb);
                chk("err_spurious_done", err_spurious_done, e_sp);
                if (core_start != '0) begin
                    start_cnt++;
                    if (exp_tile_q.size() > 0) begin
                        t = exp_tile_q.pop_front();
                        chk("core_tile_id", core_tile_id, t);
                    end else begin
                        chk("start_unexpected", core_start, 64'd0);
                    end
                end
                if (frame_done) begin
                    done_cnt++;
                    if (exp_done_q.size() > 0) begin
                        t = exp_done_q.pop_front();
                        chk("tiles_at_done", tiles_done, t);
                    end else begin
                        chk("done_unexpected", frame_done, 64'd0);
                    end
                end
            end
            sv_fs = frame_start; sv_ft = frame_tiles; sv_fsz = frame_size; sv_req = core_done_req;
        end
    end

    task automatic wait_idle();
        int guard = 0;
        while (m_phase != P_IDLE && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        if (m_phase != P_IDLE) chk("idle_timeout", m_phase, P_IDLE);
    endtask

    task automatic issue_frame(input int ft, input logic [SW-1:0] fsz);
        wait_idle();
        @(posedge clk); #1;
        for (int t = 0; t < ft; t++) exp_tile_q.push_back(t);
        exp_done_q.push_back(ft);
        frame_start = 1'b1; frame_tiles = ft[TW-1:0]; frame_size = fsz;
        @(posedge clk); #1;
        frame_start = 1'b0; frame_tiles = TW'($urandom); frame_size = $urandom;
    endtask

    task automatic run_frame(input int ft, input logic [SW-1:0] fsz, input bit poke);
        int d0;
        int guard;
        d0 = done_cnt;
        issue_frame(ft, fsz);
        if (poke) begin
            repeat (2) @(posedge clk);
            #1;
            if (m_phase == P_RUN) begin
                frame_start = 1'b1; frame_tiles = TW'($urandom); frame_size = $urandom;
                @(posedge clk); #1;
                frame_start = 1'b0;
            end
        end
        guard = 0;
        while (done_cnt == d0 && guard < 3000) begin
            @(posedge clk);
            guard++;
        end
        if (done_cnt == d0) chk("frame_timeout", done_cnt, d0 + 1);
    endtask

    // stimulus
    initial begin
        int s0;
        int guard;
        reset = 1'b1; frame_start = 1'b0; frame_tiles = '0; frame_size = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        lat_min = 10; lat_max = 10;
        run_frame(3, 32'd64, 1'b0);
        lat_min = 5; lat_max = 15;
        run_frame(20, $urandom, 1'b1);
        run_frame(0, 32'd9, 1'b0);
        for (int n = 0; n < 10; n++) begin
            lat_min = 1;
            lat_max = $urandom_range(14, 2);
            run_frame($urandom_range(30, 0), $urandom, 1'($urandom_range(1, 0)));
        end

        wait_idle();
        @(posedge clk); #1;
        spur_req++;
        repeat (4) @(posedge clk);

        lat_min = 20; lat_max = 20;
        s0 = start_cnt;
        issue_frame(30, 32'd1234);
        guard = 0;
        while (start_cnt < s0 + 5 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        if (start_cnt < s0 + 5) chk("dispatch_timeout", start_cnt, s0 + 5);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_tile_q.delete();
        exp_done_q.delete();
        #1;
        chk("reset_immediate", {core_start, core_done_ack, frame_busy, frame_done, tiles_done,
                                err_start_busy, err_spurious_done}, 64'd0);
        chk("reset_immediate_size", core_size, 64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        lat_min = 3; lat_max = 3;
        run_frame(2, 32'd77, 1'b0);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
